fabosc_clken_gen: RTL and testbench
===================================

# fabosc_clken_gen

Parametrised multi-channel clock-enable generator for the fabric oscillator clock. It is the successor to the single fixed-frequency fabric oscillator wrapper. It runs entirely on one fabric clock, the 50 MHz RC oscillator output after CLKINT. From that clock it produces NCH independent single-cycle enable strobes, each with a programmable divide ratio. Divide-ratio updates are double-buffered so that no period is ever truncated. Downstream logic uses the strobes instead of deriving extra fabric clocks.

## Interface
Parameters:
- NCH, 4, number of enable channels (1..16)
- DIVW, 16, divide-register width in bits
- DEF_DIV, 49, reset divide value for all channels (period DEF_DIV+1; 50 MHz -> 1 MHz)

Ports:
- CLK  in  1  fabric oscillator clock; single clock domain
- RST  in  1  asynchronous, active-high reset
- WR_EN  in  1  divide-register write strobe, sampled on CLK rising edge
- WR_CH  in  max(1,$clog2(NCH))  channel index for the write
- WR_DIV  in  DIVW  new divide value D; period = D+1 cycles
- CH_EN  in  NCH  per-channel run enable
- SYNC  in  1  global counter restart (present only with FABOSC_CLKEN_SYNC_EN)
- CLKEN  out  NCH  registered one-cycle enable strobes
- PEND  out  NCH  per-channel divide update pending

## Operation
Per-channel state:
- cnt[i] (DIVW bits)
- div_act[i] (DIVW bits)
- div_pnd[i] (DIVW bits)
- PEND[i]

On reset, every channel's cnt, div_act and div_pnd equal DEF_DIV. PEND is 0 and CLKEN is 0.

Per-channel update on each rising CLK edge, in priority order:
- Apply step, CH_EN[i]=0: cnt <= effective div; CLKEN[i] <= 0. If PEND[i] is set, div_act <= div_pnd and PEND clears immediately.
- Apply step, CH_EN[i]=1 and cnt==0: CLKEN[i] <= 1; cnt <= effective div. If PEND is set, div_act <= div_pnd and PEND clears.
- Apply step, CH_EN[i]=1 and cnt!=0: cnt <= cnt-1; CLKEN[i] <= 0.
- Write step: when WR_EN=1 and WR_CH==i, div_pnd <= WR_DIV and PEND[i] <= 1.
- A write in the same cycle as an apply step does not affect that apply. The reload uses the prior value, and PEND stays 1 for the next terminal count.
- A second write before the apply overwrites div_pnd; only the last value is applied.
- Writes with WR_CH >= NCH are ignored.

Arithmetic:
- Decrement only occurs when cnt!=0, so cnt never wraps below zero.
- D = 0 gives CLKEN held high continuously while enabled.
- D = 2^DIVW-1 gives the maximum period, 2^DIVW cycles.

The effective div is div_pnd when PEND is set, otherwise div_act.

## Timing
- CLKEN, PEND and all state reset asynchronously on RST high. Release is synchronous to the next CLK edge; the design must provide a synchronised deassertion.
- Take edge 0 as the first edge with CH_EN[i] sampled 1 and cnt=D. CLKEN[i] goes high after edge D for exactly one cycle, then again every D+1 edges.
- CH_EN[i] falling: CLKEN[i] is 0 after the next edge; the partial period is discarded. Re-enabling restarts the full period D+1.
- PEND[i] rises the edge after WR_EN and falls on the edge where the new value loads.
- With the channel enabled, PEND falls together with a CLKEN[i] rise.
- Channels are fully independent; simultaneous terminal counts on several channels are all honoured.
- RST mid-period aborts all counting. After release, each channel behaves exactly as from power-up.

## Configuration
Macro FABOSC_CLKEN_SYNC_EN:
- Defined: the SYNC port exists.
- SYNC=1 at an edge has highest priority. Every channel performs the reload step: pending divides are applied, PEND clears, cnt <= effective div, and CLKEN <= 0. Enabled channels then resume from a common phase.
- A WR_EN write in the same cycle as SYNC lands in div_pnd with PEND=1.
- Undefined: the SYNC port and its logic are absent; phase alignment occurs only through reset or CH_EN toggling.

## Test plan
- Reset defaults (NCH=4, DEF_DIV=49), RST pulse, then CH_EN=4'hF -> CLKEN=0 during reset. First strobe on every channel after edge 49, then one strobe every 50 cycles; PEND=0.
- Write D=0 to ch1 -> PEND[1] high until the next terminal count, then CLKEN[1] held high continuously; other channels unchanged.
- Ch0 running at D=9, write D=4 five cycles into a period -> current period completes at 10 cycles, PEND[0] falls with that strobe, subsequent period is 5 cycles.
- Back-to-back writes to ch2 (D=7 then D=3) before its terminal count -> only D=3 is applied. A write coincident with a terminal count is deferred one period.
- CH_EN[3] low mid-count, then high 20 cycles later -> CLKEN[3] is 0 the following edge. First strobe after re-enable arrives D+1 edges later. Assert RST mid-period on all channels -> all outputs 0 immediately.
- With FABOSC_CLKEN_SYNC_EN, channels at D=9 and D=19 at arbitrary phases, pulse SYNC -> CLKEN=0 that edge. Strobes realign: ch0 at +10 and ch1 at +20 edges, coincident every 20 cycles.

Source files
------------

// File: rtl/fabosc_clken_gen.sv
// fabosc_clken_gen: NCH programmable single-cycle clock-enable strobes
// derived from the 50 MHz fabric oscillator clock, with double-buffered
// divide-ratio updates so a running period is never truncated.
//
// Parameters:
//   NCH     number of enable channels (1..16)
//   DIVW    divide-register width
//   DEF_DIV reset divide value (period DEF_DIV+1 cycles)
// Ports:
//   CLK     fabric oscillator clock (single domain)
//   RST     asynchronous active-high reset, released on the next CLK edge
//   WR_EN   divide-register write strobe
//   WR_CH   channel index for the write (out-of-range indices ignored)
//   WR_DIV  new divide value D, period D+1 cycles
//   CH_EN   per-channel run enable
//   SYNC    global counter restart (only with FABOSC_CLKEN_SYNC_EN)
//   CLKEN   registered one-cycle enable strobes
//   PEND    per-channel divide update pending
// Optional feature macro: FABOSC_CLKEN_SYNC_EN adds the SYNC port.

module fabosc_clken_gen #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned DIVW    = 16,
   parameter int unsigned DEF_DIV = 49
) (
   input  logic                                 CLK,
   input  logic                                 RST,
   input  logic                                 WR_EN,
   input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] WR_CH,
   input  logic [DIVW-1:0]                      WR_DIV,
   input  logic [NCH-1:0]                       CH_EN,
`ifdef FABOSC_CLKEN_SYNC_EN
   input  logic                                 SYNC,
`endif
   output logic [NCH-1:0]                       CLKEN,
   output logic [NCH-1:0]                       PEND
);

   localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [DIVW-1:0] DEF = DIVW'(DEF_DIV);

   // Reset asserts immediately; rst_q clears on the first CLK edge after
   // RST falls, so every channel leaves reset on a clean edge.
   logic rst_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) rst_q <= 1'b1;
      else     rst_q <= 1'b0;
   end

   logic sync_w;

`ifdef FABOSC_CLKEN_SYNC_EN
   assign sync_w = SYNC;
`else
   assign sync_w = 1'b0;
`endif

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [DIVW-1:0] cnt_q;
      logic [DIVW-1:0] act_q;
      logic [DIVW-1:0] pnd_q;
      logic [DIVW-1:0] eff;
      logic            clken_q;
      logic            pend_q;
      logic            wr_hit;
      logic            tc;
      logic            reload;

      assign wr_hit = WR_EN && (WR_CH == CHW'(i));
      // A pending value takes effect on the reload that consumes it.
      assign eff    = pend_q ? pnd_q : act_q;
      assign tc     = CH_EN[i] && (cnt_q == '0);
      // Disabled channels reload every cycle so re-enable starts a full
      // period; SYNC forces the same reload on every channel.
      assign reload = sync_w || !CH_EN[i] || tc;

      always_ff @(posedge CLK or posedge rst_q) begin
         if (rst_q) begin
            cnt_q   <= DEF;
            act_q   <= DEF;
            pnd_q   <= DEF;
            clken_q <= 1'b0;
            pend_q  <= 1'b0;
         end else begin
            clken_q <= tc && !sync_w;
            if (reload) begin
               cnt_q <= eff;
               if (pend_q) begin
                  act_q  <= pnd_q;
                  pend_q <= 1'b0;
               end
            end else begin
               cnt_q <= cnt_q - DIVW'(1);
            end
            // Write after apply: a coincident write is held for the
            // next reload rather than altering this one.
            if (wr_hit) begin
               pnd_q  <= WR_DIV;
               pend_q <= 1'b1;
            end
         end
      end

      assign CLKEN[i] = clken_q;
      assign PEND[i]  = pend_q;
   end

endmodule

// File: tb/tb_fabosc_clken_gen.sv
// tb_fabosc_clken_gen: scoreboard bench for fabosc_clken_gen.
// Expected strobe cycles are queued per channel; a monitor pops them.

module tb_fabosc_clken_gen;

   localparam int NCH = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       WR_EN = 1'b0;
   logic [1:0] WR_CH = '0;
   logic [15:0] WR_DIV = '0;
   logic [3:0] CH_EN = 4'hF;
`ifdef FABOSC_CLKEN_SYNC_EN
   logic       SYNC = 1'b0;
`endif
   logic [3:0] CLKEN;
   logic [3:0] PEND;

   int cyc = 0;
   int n_vec = 0;
   int n_bad = 0;
   int exp_q [NCH][$];
   logic [3:0] chk = 4'h0;

   fabosc_clken_gen #(.NCH(4), .DIVW(16), .DEF_DIV(49)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .WR_EN  (WR_EN),
      .WR_CH  (WR_CH),
      .WR_DIV (WR_DIV),
      .CH_EN  (CH_EN),
`ifdef FABOSC_CLKEN_SYNC_EN
      .SYNC   (SYNC),
`endif
      .CLKEN  (CLKEN),
      .PEND   (PEND)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: cycle %0d reached time limit, required finish", cyc);
      $fatal(1);
   end

   // Monitor: sampled 1 time unit after each rising edge.
   initial begin
      int e;
      forever begin
         @(posedge CLK);
         #1;
         for (int i = 0; i < NCH; i++) begin
            if (chk[i]) begin
               if (CLKEN[i]) begin
                  n_vec++;
                  if (exp_q[i].size() == 0) begin
                     n_bad++;
                     $display("FAIL strobe ch%0d: got strobe at cycle %0d, required none", i, cyc);
                  end else begin
                     e = exp_q[i].pop_front();
                     if (e != cyc) begin
                        n_bad++;
                        $display("FAIL strobe ch%0d: got strobe at cycle %0d, required cycle %0d", i, cyc, e);
                     end
                  end
               end else if (exp_q[i].size() != 0 && exp_q[i][0] <= cyc) begin
                  n_vec++;
                  n_bad++;
                  e = exp_q[i].pop_front();
                  $display("FAIL strobe ch%0d: got no strobe at cycle %0d, required one at %0d", i, cyc, e);
               end
            end
         end
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h at cycle %0d, required %0h", nm, act, cyc, exp);
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge CLK);
   endtask

   task automatic push(input int ch, input int first, input int step, input int n);
      for (int k = 0; k < n; k++) exp_q[ch].push_back(first + k * step);
   endtask

   // Write issued at negedge c, sampled on rising edge c+1.
   task automatic write(input int ch, input int d, input int c);
      wait_cyc(c);
      WR_EN  = 1'b1;
      WR_CH  = 2'(ch);
      WR_DIV = 16'(d);
      @(negedge CLK);
      WR_EN  = 1'b0;
   endtask

   initial begin
      // RST released at negedge 3; rst clears on edge 4; edge 5 is edge 0.
      wait_cyc(2);
      check("reset CLKEN", int'(CLKEN), 0);
      check("reset PEND", int'(PEND), 0);
      wait_cyc(3);
      RST = 1'b0;

      push(0, 54, 50, 5);
      push(0, 264, 10, 3);
      push(0, 289, 5, 3);
      push(1, 54, 50, 3);
      push(1, 204, 1, 10);
      push(2, 54, 50, 5);
      push(2, 304, 4, 4);
      push(2, 320, 6, 3);
      push(3, 54, 50, 7);
      push(3, 439, 50, 1);

      wait_cyc(4);
      check("release CLKEN", int'(CLKEN), 0);
      chk = 4'hF;

      // ch1 -> D=0: pending until its terminal count at 204.
      write(1, 0, 160);
      check("ch1 PEND set", int'(PEND), 4'h2);
      wait_cyc(203);
      check("ch1 PEND held", int'(PEND[1]), 1);
      wait_cyc(204);
      check("ch1 PEND clear", int'(PEND), 0);
      wait_cyc(213);
      chk[1] = 1'b0;

      // ch0 -> D=9, then D=4 five cycles into a period.
      write(0, 9, 220);
      check("ch0 PEND set", int'(PEND), 4'h1);
      wait_cyc(254);
      check("ch0 PEND clear", int'(PEND[0]), 0);
      write(0, 4, 278);
      wait_cyc(283);
      check("ch0 PEND mid", int'(PEND[0]), 1);
      wait_cyc(284);
      check("ch0 PEND fall", int'(PEND[0]), 0);

      // ch2 back-to-back writes: only D=3 is applied.
      wait_cyc(289);
      WR_EN  = 1'b1;
      WR_CH  = 2'd2;
      WR_DIV = 16'd7;
      @(negedge CLK);
      WR_DIV = 16'd3;
      @(negedge CLK);
      WR_EN  = 1'b0;
      check("ch2 PEND set", int'(PEND[2]), 1);
      wait_cyc(299);
      chk[0] = 1'b0;
      wait_cyc(304);
      check("ch2 PEND clear", int'(PEND[2]), 0);
      // Write coincident with terminal count 316 is deferred to 320.
      write(2, 5, 315);
      check("ch2 coincident PEND", int'(PEND[2]), 1);
      wait_cyc(319);
      check("ch2 deferred PEND", int'(PEND[2]), 1);
      wait_cyc(320);
      check("ch2 deferred clear", int'(PEND[2]), 0);
      wait_cyc(332);
      chk[2] = 1'b0;

      // ch3 disabled 370..389, full period restarts from edge 390.
      wait_cyc(369);
      CH_EN[3] = 1'b0;
      wait_cyc(389);
      CH_EN[3] = 1'b1;

      // ch1 at D=0 held high; disable drops it the next edge.
      wait_cyc(399);
      check("ch1 held high", int'(CLKEN[1]), 1);
      chk[1] = 1'b1;
      CH_EN[1] = 1'b0;
      wait_cyc(400);
      check("ch1 disable", int'(CLKEN[1]), 0);
      wait_cyc(409);
      CH_EN[1] = 1'b1;
      push(1, 410, 1, 5);
      wait_cyc(414);
      chk[1] = 1'b0;

      // Reset mid-period clears everything at once.
      write(3, 20, 444);
      wait_cyc(449);
      check("pre-reset PEND", int'(PEND), 4'h8);
      check("pre-reset ch1", int'(CLKEN[1]), 1);
      wait_cyc(450);
      chk = 4'h0;
      RST = 1'b1;
      #1;
      check("async reset CLKEN", int'(CLKEN), 0);
      check("async reset PEND", int'(PEND), 0);

      for (int i = 0; i < NCH; i++) begin
         check($sformatf("ch%0d queue drained", i), exp_q[i].size(), 0);
         push(i, 511, 50, 2);
      end
`ifdef FABOSC_CLKEN_SYNC_EN
      push(0, 611, 1, 1);
      push(0, 631, 10, 5);
      push(1, 611, 1, 1);
      push(1, 641, 20, 2);
      push(2, 611, 60, 2);
      push(3, 611, 60, 2);
`endif
      wait_cyc(460);
      RST = 1'b0;
      chk = 4'hF;
      wait_cyc(461);
      check("re-release CLKEN", int'(CLKEN), 0);
      wait_cyc(570);

`ifdef FABOSC_CLKEN_SYNC_EN
      write(0, 9, 570);
      write(1, 19, 571);
      wait_cyc(610);
      check("sync pre PEND", int'(PEND), 4'h3);
      wait_cyc(611);
      check("sync load PEND", int'(PEND), 0);
      // SYNC on edge 621 (ch0 terminal count) with a ch2 write.
      wait_cyc(620);
      SYNC   = 1'b1;
      WR_EN  = 1'b1;
      WR_CH  = 2'd2;
      WR_DIV = 16'd7;
      @(negedge CLK);
      SYNC  = 1'b0;
      WR_EN = 1'b0;
      check("sync CLKEN", int'(CLKEN), 0);
      check("sync write PEND", int'(PEND), 4'h4);
      wait_cyc(670);
      check("sync ch2 PEND held", int'(PEND[2]), 1);
      wait_cyc(671);
      check("sync ch2 PEND clear", int'(PEND), 0);
      wait_cyc(680);
`endif

      for (int i = 0; i < NCH; i++)
         check($sformatf("ch%0d final drain", i), exp_q[i].size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
